load_writeback_unit: RTL and testbench
======================================

LOAD_WRITEBACK_UNIT -- requirements
Module: load_writeback_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: cycles in MEM with mem_ready low before abort.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  load request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_opcode  input  6  34=lbz, 40=lhz, 42=lha, 32=lwz, 58=ld.
REQ-007 SHALL have port req_addr  input  64  effective byte address.
REQ-008 SHALL have port req_rd  input  5  destination register index.
REQ-009 SHALL have port mem_rd_en  output  1  memory read strobe.
REQ-010 SHALL have port mem_addr  output  64  doubleword-aligned read address.
REQ-011 SHALL have port mem_ready  input  1  mem_rdata valid this cycle.
REQ-012 SHALL have port mem_rdata  input  64  doubleword read data.
REQ-013 SHALL have port wb_en  output  1  register-file write strobe (RegWrite).
REQ-014 SHALL have port wb_rd  output  5  register-file write index.
REQ-015 SHALL have port wb_data  output  64  fully extended register value.
REQ-016 SHALL have port err  output  1  one-cycle pulse: illegal opcode, misalignment, or timeout.

Function
REQ-017 SHALL implement FSM states IDLE, MEM, WB; req_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, req_valid&&req_ready SHALL latch opcode, addr, rd and go to MEM, unless the request is illegal.
REQ-019 Illegal request (opcode outside REQ-006, or addr[0]!=0 for lhz/lha, addr[1:0]!=0 for lwz, addr[2:0]!=0 for ld) SHALL pulse err next cycle, stay IDLE, issue no memory read, no writeback.
REQ-020 In MEM, mem_rd_en SHALL be 1 and mem_addr SHALL equal {addr[63:3],3'b000}, held stable until mem_ready sampled 1.
REQ-021 On mem_ready=1 in MEM, SHALL capture mem_rdata and go to WB; mem_ready outside MEM SHALL be ignored.
REQ-022 Byte lanes little-endian: byte at offset k = addr[2:0] is mem_rdata[8k+7:8k].
REQ-023 Extension: lbz zero-extends 8 bits; lhz zero-extends 16; lha sign-extends 16 from bit 15; lwz zero-extends 32; ld passes 64 unchanged.
REQ-024 In WB, wb_en SHALL be 1 for exactly one cycle with wb_rd=latched rd and wb_data per REQ-022/023; next state IDLE.
REQ-025 wb_rd and wb_data SHALL be 0 whenever wb_en=0.
REQ-026 Latency: accept at edge N -> mem_rd_en from cycle N+1 -> wb_en in cycle after mem_ready sampled; minimum accept-to-wb_en 2 cycles.
REQ-027 Timeout counter SHALL clear on entering MEM, increment each MEM cycle with mem_ready=0; on reaching MEM_TIMEOUT SHALL pulse err, drop mem_rd_en, return IDLE, no writeback.
REQ-028 mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT SHALL count as success (no err).
REQ-029 Back-to-back requests: after WB, next request accepted in IDLE; no more than one load in flight.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, clear counter and latches; req_ready=1, mem_rd_en=0, mem_addr=0, wb_en=0, wb_rd=0, wb_data=0, err=0 from next cycle.
REQ-031 Reset mid-MEM or mid-WB SHALL abort the load with no wb_en and no err pulse; late mem_ready SHALL be ignored.

Structure
REQ-032 Opcode constants (34, 40, 42, 32, 58) and FSM state encodings SHALL live in the shared uPower package, reused by decoder and register file.
REQ-033 Lane select and extension SHALL be a combinational sub-module load_extract (opcode, offset, rdata -> value).

Verification
REQ-034 lbz addr=0x1003, rdata=0x8877665544332211, mem_ready after 3 cycles -> mem_addr=0x1000, wb_data=0x44, wb_en one cycle.
REQ-035 lha addr=0x2006, rdata=0x80FF000000000000 -> wb_data=0xFFFFFFFFFFFF80FF; lhz same -> 0x00000000000080FF.
REQ-036 lwz addr=0x3002 -> err pulse next cycle, mem_rd_en never 1, wb_en never 1; opcode 7 -> same.
REQ-037 ld addr=0x4000, mem_ready held 0 -> err after exactly 16 MEM cycles, return IDLE; mem_ready on 16th cycle -> wb_en, no err.
REQ-038 rst asserted during MEM, then mem_ready=1 -> no wb_en, outputs at reset values, next request accepted normally.
REQ-039 Two back-to-back ld requests, mem_ready immediate -> wb_en 2 cycles after each accept, rd values in order.

Source files
------------

// File: rtl/load_writeback_unit_pkg.sv
// load_writeback_unit_pkg: shared load opcodes, FSM encoding and legality check
package load_writeback_unit_pkg;
    localparam logic [5:0] OP_LBZ = 6'd34;
    localparam logic [5:0] OP_LHZ = 6'd40;
    localparam logic [5:0] OP_LHA = 6'd42;
    localparam logic [5:0] OP_LWZ = 6'd32;
    localparam logic [5:0] OP_LD  = 6'd58;
    typedef enum logic [1:0] {IDLE, MEM, WB} state_t;
    function automatic logic load_legal(input logic [5:0] op, input logic [2:0] off);
        return op == OP_LBZ
            || ((op == OP_LHZ || op == OP_LHA) && !off[0])
            || (op == OP_LWZ && off[1:0] == 2'b00)
            || (op == OP_LD && off == 3'b000);
    endfunction
endpackage

// File: rtl/load_writeback_unit_extract.sv
// load_extract: little-endian lane select and zero/sign extension of a loaded doubleword
module load_extract
    import load_writeback_unit_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [2:0]  offset,
    input  logic [63:0] rdata,
    output logic [63:0] value
);
    logic [63:0] sh;
    always_comb begin
        sh = rdata >> {offset, 3'b000};
        value = opcode == OP_LBZ ? {56'b0, sh[7:0]} :
                opcode == OP_LHZ ? {48'b0, sh[15:0]} :
                opcode == OP_LHA ? {{48{sh[15]}}, sh[15:0]} :
                opcode == OP_LWZ ? {32'b0, sh[31:0]} : sh;
    end
endmodule

// File: rtl/load_writeback_unit.sv
// load_writeback_unit: single-outstanding load FSM with alignment check, timeout and writeback
module load_writeback_unit
    import load_writeback_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_opcode,
    input  logic [63:0] req_addr,
    input  logic [4:0]  req_rd,
    output logic        mem_rd_en,
    output logic [63:0] mem_addr,
    input  logic        mem_ready,
    input  logic [63:0] mem_rdata,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        err
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    state_t state, state_nx;
    logic [5:0] op;
    logic [63:0] addr, data, ext;
    logic [4:0] rd;
    logic [CW-1:0] cnt;
    logic err_q, accept, legal, timeout;
    load_extract u_extract (.opcode(op), .offset(addr[2:0]), .rdata(data), .value(ext));
    always_comb begin
        accept = state == IDLE && req_valid;
        legal = load_legal(req_opcode, req_addr[2:0]);
        // a response arriving on the final allowed cycle wins over the timeout
        timeout = state == MEM && !mem_ready && cnt == CW'(MEM_TIMEOUT - 1);
        state_nx = state == IDLE ? (accept && legal ? MEM : IDLE) :
                   state == MEM  ? (mem_ready ? WB : timeout ? IDLE : MEM) : IDLE;
        req_ready = state == IDLE;
        mem_rd_en = state == MEM;
        mem_addr = mem_rd_en ? {addr[63:3], 3'b000} : 64'd0;
        wb_en = state == WB;
        wb_rd = wb_en ? rd : 5'd0;
        wb_data = wb_en ? ext : 64'd0;
        err = err_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op <= '0;
            addr <= '0;
            rd <= '0;
            data <= '0;
            cnt <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= (accept && !legal) || timeout;
            if (accept && legal) begin
                op <= req_opcode;
                addr <= req_addr;
                rd <= req_rd;
                cnt <= '0;
            end
            if (state == MEM && mem_ready) data <= mem_rdata;
            if (state == MEM && !mem_ready) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_load_writeback_unit.sv
// tb_load_writeback_unit: directed self-checking bench for load_writeback_unit
module tb_load_writeback_unit;
    logic clk = 1'b0;
    logic rst, req_valid, req_ready, mem_rd_en, mem_ready, wb_en, err;
    logic [5:0] req_opcode;
    logic [63:0] req_addr, mem_addr, mem_rdata, wb_data;
    logic [4:0] req_rd, wb_rd;
    int n_cmp = 0;
    int n_err = 0;

    load_writeback_unit #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_addr(req_addr), .req_rd(req_rd),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " req_ready"}, {63'd0, req_ready}, 64'd1);
        chk({tag, " mem_rd_en"}, {63'd0, mem_rd_en}, 64'd0);
        chk({tag, " mem_addr"}, mem_addr, 64'd0);
        chk({tag, " wb_en"}, {63'd0, wb_en}, 64'd0);
        chk({tag, " wb_rd"}, {59'd0, wb_rd}, 64'd0);
        chk({tag, " wb_data"}, wb_data, 64'd0);
    endtask

    task automatic do_load(input string tag, input logic [5:0] op, input logic [63:0] a,
                           input logic [63:0] exp_maddr, input logic [4:0] r,
                           input logic [63:0] rdata, input int waits, input logic [63:0] exp);
        req_valid = 1'b1; req_opcode = op; req_addr = a; req_rd = r;
        chk({tag, " req_ready"}, {63'd0, req_ready}, 64'd1);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < waits; i++) begin
            chk({tag, " wait mem_rd_en"}, {63'd0, mem_rd_en}, 64'd1);
            chk({tag, " wait mem_addr"}, mem_addr, exp_maddr);
            chk({tag, " wait wb_en"}, {63'd0, wb_en}, 64'd0);
            step();
        end
        chk({tag, " mem_rd_en"}, {63'd0, mem_rd_en}, 64'd1);
        chk({tag, " mem_addr"}, mem_addr, exp_maddr);
        chk({tag, " req_ready busy"}, {63'd0, req_ready}, 64'd0);
        chk({tag, " err mem"}, {63'd0, err}, 64'd0);
        mem_ready = 1'b1; mem_rdata = rdata;
        step();
        mem_ready = 1'b0; mem_rdata = ~rdata;
        chk({tag, " wb_en"}, {63'd0, wb_en}, 64'd1);
        chk({tag, " wb_rd"}, {59'd0, wb_rd}, {59'd0, r});
        chk({tag, " wb_data"}, wb_data, exp);
        chk({tag, " err wb"}, {63'd0, err}, 64'd0);
        chk({tag, " mem_rd_en wb"}, {63'd0, mem_rd_en}, 64'd0);
        step();
        chk_idle({tag, " after"});
        chk({tag, " err after"}, {63'd0, err}, 64'd0);
    endtask

    task automatic do_illegal(input string tag, input logic [5:0] op, input logic [63:0] a);
        req_valid = 1'b1; req_opcode = op; req_addr = a; req_rd = 5'd7;
        step();
        req_valid = 1'b0;
        chk({tag, " err"}, {63'd0, err}, 64'd1);
        chk_idle({tag, " pulse"});
        step();
        chk({tag, " err drop"}, {63'd0, err}, 64'd0);
        chk_idle({tag, " later"});
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_opcode = '0; req_addr = '0; req_rd = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        step();
        step();
        rst = 1'b0;
        chk_idle("reset");
        chk("reset err", {63'd0, err}, 64'd0);

        // mem_ready outside MEM must be ignored
        mem_ready = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_0001;
        step();
        mem_ready = 1'b0;
        chk_idle("stray ready");

        do_load("lbz", 6'd34, 64'h1003, 64'h1000, 5'd5, 64'h8877665544332211, 2, 64'h44);
        do_load("lha", 6'd42, 64'h2006, 64'h2000, 5'd6, 64'h80FF000000000000, 0, 64'hFFFFFFFFFFFF80FF);
        do_load("lhz", 6'd40, 64'h2006, 64'h2000, 5'd7, 64'h80FF000000000000, 1, 64'h00000000000080FF);
        do_load("lwz", 6'd32, 64'h3004, 64'h3000, 5'd8, 64'h8877665544332211, 0, 64'h0000000088776655);
        do_load("lbz0", 6'd34, 64'h1008, 64'h1008, 5'd9, 64'h00000000000000F1, 0, 64'h00000000000000F1);

        do_illegal("lwz misaligned", 6'd32, 64'h3002);
        do_illegal("opcode 7", 6'd7, 64'h3000);
        do_illegal("lhz odd", 6'd40, 64'h2001);
        do_illegal("ld misaligned", 6'd58, 64'h4004);

        // timeout: 16 MEM cycles with mem_ready low
        req_valid = 1'b1; req_opcode = 6'd58; req_addr = 64'h4000; req_rd = 5'd10;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("timeout mem_rd_en", {63'd0, mem_rd_en}, 64'd1);
            chk("timeout err early", {63'd0, err}, 64'd0);
            step();
        end
        chk("timeout err", {63'd0, err}, 64'd1);
        chk_idle("timeout");
        step();
        chk("timeout err drop", {63'd0, err}, 64'd0);

        // response on the 16th MEM cycle is a success
        do_load("ld edge", 6'd58, 64'h4000, 64'h4000, 5'd11, 64'h0123456789ABCDEF, 15, 64'h0123456789ABCDEF);

        // reset during MEM aborts silently
        req_valid = 1'b1; req_opcode = 6'd58; req_addr = 64'h4100; req_rd = 5'd12;
        step();
        req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_ready = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        chk_idle("rst mid");
        chk("rst mid err", {63'd0, err}, 64'd0);
        step();
        mem_ready = 1'b0;
        chk_idle("rst late ready");
        chk("rst late err", {63'd0, err}, 64'd0);
        do_load("ld post rst", 6'd58, 64'h4100, 64'h4100, 5'd13, 64'hA5A5_5A5A_0F0F_F0F0, 0, 64'hA5A5_5A5A_0F0F_F0F0);

        do_load("ld b2b 1", 6'd58, 64'h5000, 64'h5000, 5'd1, 64'h1111_2222_3333_4444, 0, 64'h1111_2222_3333_4444);
        do_load("ld b2b 2", 6'd58, 64'h5008, 64'h5008, 5'd2, 64'h5555_6666_7777_8888, 0, 64'h5555_6666_7777_8888);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
